// File: rtl/axis_checksum_trailer.sv
// ---------------------------------------------------------------------------
// axis_checksum_trailer
//
// Purpose:
//   Stream kernel placed between the datamover MM2S output (h2s) and its S2MM
//   input (s2h). Every h2s packet is passed through, optionally byte swapped
//   per word, and is then followed by one trailer word:
//     trailer = {word_count[31:0], csum[63:32] ^ csum[31:0]}
//   where csum is the XOR of all unswapped input words of the packet. Host
//   software can use the trailer to check the DMA path end to end.
//   The output is fully registered and the block sustains one word per clock.
//   With a trailer, each packet costs one input bubble cycle.
//
// Parameters:
//   C_AXIS_DATA_WIDTH  stream width, only 64 is supported
//   C_CNT_WIDTH        width of the pkt_count status counter
//
// Ports:
//   clk             single clock for all logic
//   aresetn         synchronous, active-low reset
//   s_axis_tdata    input word (from datamover MM2S)
//   s_axis_tvalid   input valid
//   s_axis_tready   input ready (low during reset and while emitting a trailer)
//   s_axis_tlast    last word of input packet
//   m_axis_tdata    output word (to datamover S2MM)
//   m_axis_tvalid   output valid
//   m_axis_tready   output ready
//   m_axis_tlast    last word of output packet
//   cfg_byteswap    1 = reverse byte order of data words
//   cfg_trailer_en  1 = append trailer, 0 = pure pass-through
//   pkt_count       packets fully emitted, wraps modulo 2^C_CNT_WIDTH
//   busy            high while a packet is in flight or output is valid
// ---------------------------------------------------------------------------
module axis_checksum_trailer #(
  parameter int C_AXIS_DATA_WIDTH = 64,
  parameter int C_CNT_WIDTH       = 32
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  input  logic                         cfg_byteswap,
  input  logic                         cfg_trailer_en,
  output logic [C_CNT_WIDTH-1:0]       pkt_count,
  output logic                         busy
);

  localparam int DW = C_AXIS_DATA_WIDTH;

  // The byte swap and the trailer layout are written for 64-bit words only.
  if (C_AXIS_DATA_WIDTH != 64) begin : g_bad_width
    $error("axis_checksum_trailer: C_AXIS_DATA_WIDTH must be 64");
  end

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TRAIL
  } state_t;

  state_t        state;
  logic          swp;
  logic          trl_en;
  logic [31:0]   wcnt;
  logic [DW-1:0] csum;

  logic          load_ok;
  logic          accept;
  logic          eff_swp;
  logic          eff_trl;
  logic [DW-1:0] data_word;
  logic [DW-1:0] trailer_word;

  // Reverse the byte order of one 64-bit word.
  function automatic logic [63:0] bswap64(input logic [63:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24],
            d[39:32], d[47:40], d[55:48], d[63:56]};
  endfunction

  // The output register may be (re)loaded when it is empty or being drained
  // this cycle. The input is stalled while the trailer is pending.
  always_comb begin
    load_ok       = !m_axis_tvalid || m_axis_tready;
    s_axis_tready = aresetn && (state != TRAIL) && load_ok;
    accept        = s_axis_tvalid && s_axis_tready;
  end

  // The first word of a packet is accepted in IDLE and must already use the
  // live cfg values, since the latched copies are only written on that same
  // edge. All later words use the latched copies.
  always_comb begin
    eff_swp      = (state == IDLE) ? cfg_byteswap   : swp;
    eff_trl      = (state == IDLE) ? cfg_trailer_en : trl_en;
    data_word    = eff_swp ? bswap64(s_axis_tdata) : s_axis_tdata;
    trailer_word = {wcnt, csum[63:32] ^ csum[31:0]};
  end

  assign busy = (state != IDLE) || m_axis_tvalid;

  // Main FSM together with the registered output stage and the accumulators.
  // In TRAIL the accumulators already include the packet's last word, so
  // the trailer is built directly from them and they are cleared on load.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state         <= IDLE;
      swp           <= 1'b0;
      trl_en        <= 1'b0;
      wcnt          <= '0;
      csum          <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      pkt_count     <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        pkt_count <= pkt_count + C_CNT_WIDTH'(1);
      end

      if (state == TRAIL) begin
        if (load_ok) begin
          m_axis_tdata  <= trailer_word;
          m_axis_tlast  <= 1'b1;
          m_axis_tvalid <= 1'b1;
          wcnt          <= '0;
          csum          <= '0;
          state         <= IDLE;
        end
      end else if (accept) begin
        m_axis_tdata  <= data_word;
        m_axis_tlast  <= s_axis_tlast && !eff_trl;
        m_axis_tvalid <= 1'b1;

        if (state == IDLE) begin
          swp    <= cfg_byteswap;
          trl_en <= cfg_trailer_en;
        end

        if (s_axis_tlast) begin
          if (eff_trl) begin
            wcnt  <= wcnt + 32'd1;
            csum  <= csum ^ s_axis_tdata;
            state <= TRAIL;
          end else begin
            // No trailer: the packet ends here, so start the next one clean.
            wcnt  <= '0;
            csum  <= '0;
            state <= IDLE;
          end
        end else begin
          wcnt  <= wcnt + 32'd1;
          csum  <= csum ^ s_axis_tdata;
          state <= DATA;
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
